// File: rtl/layer_sequencer.sv
// Control sequencer for one fully-connected layer: it reads weights and inputs, drives the MAC, the tanh unit and the output write-back.
// Optional bias row term: define LAYER_SEQUENCER_BIAS_EN to add the x_bias port and one extra ISSUE cycle per neuron.
module layer_sequencer #(
    parameter int AW      = 8,
    parameter int MAC_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    num_in,
    input  logic [7:0]    num_out,
    output logic [AW-1:0] w_addr,
    output logic [AW-1:0] x_addr,
    output logic          mem_rd,
    output logic          mac_clr,
    output logic          mac_ce,
    output logic          act_start,
    input  logic          act_done,
    output logic          out_we,
    output logic [7:0]    out_addr,
`ifdef LAYER_SEQUENCER_BIAS_EN
    output logic          x_bias,
`endif
    output logic          busy,
    output logic          done
);

    typedef enum logic [3:0] {
        IDLE, CLR, ISSUE, DRAIN, LAT, ACT, WAIT, STORE, FIN
    } state_t;

    localparam logic [7:0] LAT_LAST = 8'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

    state_t        state, next;
    logic [7:0]    i_cnt, j_cnt, lat_cnt;
    logic [7:0]    n_in, n_out;
    logic [AW-1:0] w_cnt;
    logic          armed;
    logic          mac_ce_p1;
    logic          accept;
    logic          row_end;

    // Start is refused on the first edge after reset release (armed still 0).
    assign accept = (state == IDLE) && start && armed;

`ifdef LAYER_SEQUENCER_BIAS_EN
    // The bias term occupies the slot just past the last real input.
    assign x_bias  = (state == ISSUE) && (i_cnt == n_in);
    assign row_end = (i_cnt == n_in);
`else
    assign row_end = (i_cnt == n_in - 8'd1);
`endif

    always_comb begin
        next      = state;
        mac_clr   = 1'b0;
        mem_rd    = 1'b0;
        act_start = 1'b0;
        out_we    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (accept) next = (num_in == 8'd0 || num_out == 8'd0) ? FIN : CLR;
            CLR:   begin mac_clr = 1'b1; next = ISSUE; end
            ISSUE: begin mem_rd = 1'b1; if (row_end) next = DRAIN; end
            DRAIN: next = (MAC_LAT == 0) ? ACT : LAT;
            LAT:   if (lat_cnt == LAT_LAST) next = ACT;
            ACT:   begin act_start = 1'b1; next = WAIT; end
            WAIT:  if (act_done) next = STORE;
            STORE: begin out_we = 1'b1; next = (j_cnt == n_out - 8'd1) ? FIN : CLR; end
            FIN:   begin done = 1'b1; next = IDLE; end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            i_cnt     <= 8'd0;
            j_cnt     <= 8'd0;
            lat_cnt   <= 8'd0;
            w_cnt     <= '0;
            armed     <= 1'b0;
            mac_ce_p1 <= 1'b0;
        end else begin
            state     <= next;
            armed     <= 1'b1;
            mac_ce_p1 <= mem_rd;
            if (accept) begin
                i_cnt <= 8'd0;
                j_cnt <= 8'd0;
                w_cnt <= '0;
            end
            if (state == ISSUE) begin
                i_cnt <= i_cnt + 8'd1;
                w_cnt <= w_cnt + 1'b1;
            end
            if (state == DRAIN) lat_cnt <= 8'd0;
            if (state == LAT)   lat_cnt <= lat_cnt + 8'd1;
            if (state == STORE && next == CLR) begin
                j_cnt <= j_cnt + 8'd1;
                i_cnt <= 8'd0;
            end
        end
    end

    // Layer dimensions are held for the whole run; they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            n_in  <= num_in;
            n_out <= num_out;
        end
    end

    assign mac_ce   = mac_ce_p1;
    assign w_addr   = w_cnt;
    assign x_addr   = AW'(i_cnt);
    assign out_addr = j_cnt;
    assign busy     = (state != IDLE) && (state != FIN);

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer; a tanh-unit responder answers act_start after 4 cycles or holds act_done high.
module tb_layer_sequencer;
    localparam int AW = 8;
`ifdef LAYER_SEQUENCER_BIAS_EN
    localparam int BIAS = 1;
`else
    localparam int BIAS = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    num_in = 8'd0;
    logic [7:0]    num_out = 8'd0;
    logic [AW-1:0] w_addr, x_addr;
    logic          mem_rd, mac_clr, mac_ce, act_start, out_we, busy, done;
    logic          act_done = 1'b0;
    logic [7:0]    out_addr;
    logic          x_bias;

    layer_sequencer #(.AW(AW), .MAC_LAT(2)) dut (
        .clk(clk), .reset(reset), .start(start), .num_in(num_in), .num_out(num_out),
        .w_addr(w_addr), .x_addr(x_addr), .mem_rd(mem_rd), .mac_clr(mac_clr),
        .mac_ce(mac_ce), .act_start(act_start), .act_done(act_done),
        .out_we(out_we), .out_addr(out_addr),
`ifdef LAYER_SEQUENCER_BIAS_EN
        .x_bias(x_bias),
`endif
        .busy(busy), .done(done)
    );
`ifndef LAYER_SEQUENCER_BIAS_EN
    assign x_bias = 1'b0;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int n_rd, n_ce, n_clr, n_we, n_done, n_bias, ce_err, done_cyc, t_start;
    int wlog[64];
    int xlog[64];
    int olog[16];
    int bias_w[8];
    logic prev_rd = 1'b0;
    logic act_mode = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (mac_ce !== prev_rd) ce_err++;
            prev_rd = mem_rd;
            if (mem_rd) begin
                if (n_rd < 64) begin
                    wlog[n_rd] = int'(w_addr);
                    xlog[n_rd] = int'(x_addr);
                end
                n_rd++;
                if (x_bias) begin
                    if (n_bias < 8) bias_w[n_bias] = int'(w_addr);
                    n_bias++;
                end
            end
            if (mac_ce)  n_ce++;
            if (mac_clr) n_clr++;
            if (out_we) begin
                if (n_we < 16) olog[n_we] = int'(out_addr);
                n_we++;
            end
            if (done) begin
                if (n_done == 0) done_cyc = cyc + 1;
                n_done++;
            end
        end
    end

    // Tanh unit model.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (act_mode) act_done = 1'b1;
            else begin
                act_done = 1'b0;
                if (act_start) cnt = 4;
                else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) act_done = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_log();
        n_rd = 0; n_ce = 0; n_clr = 0; n_we = 0; n_done = 0; n_bias = 0;
        ce_err = 0; done_cyc = -1;
    endtask

    task automatic start_layer(input int ni, input int no);
        start = 1'b1;
        num_in = 8'(ni);
        num_out = 8'(no);
        t_start = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int n = 0; n < budget && n_done == 0; n++) step();
        chk("done_seen", n_done, 1);
        for (int n = 0; n < 3; n++) step();
        chk("done_once", n_done, 1);
        chk("busy_after", int'(busy), 0);
        chk("ce_follows_rd", ce_err, 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mem_rd"}, int'(mem_rd), 0);
        chk({tag, "_mac_ce"}, int'(mac_ce), 0);
        chk({tag, "_mac_clr"}, int'(mac_clr), 0);
        chk({tag, "_act_start"}, int'(act_start), 0);
        chk({tag, "_out_we"}, int'(out_we), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_w_addr"}, int'(w_addr), 0);
        chk({tag, "_x_addr"}, int'(x_addr), 0);
        chk({tag, "_out_addr"}, int'(out_addr), 0);
        chk({tag, "_x_bias"}, int'(x_bias), 0);
    endtask

    initial begin
        clear_log();
        reset = 1'b0;
        repeat (3) step();
        chk_idle_outputs("reset");
        reset = 1'b1;
        repeat (2) step();

        // 3 inputs x 2 neurons, act_done 4 cycles after act_start
        clear_log();
        start_layer(3, 2);
        wait_done(200);
        chk("l1_mac_ce", n_ce, BIAS ? 8 : 6);
        chk("l1_mem_rd", n_rd, BIAS ? 8 : 6);
        chk("l1_mac_clr", n_clr, 2);
        for (int k = 0; k < (BIAS ? 8 : 6); k++) chk("l1_w_addr", wlog[k], k);
        for (int k = 0; k < 3; k++) begin
            chk("l1_x_addr_n0", xlog[k], k);
            chk("l1_x_addr_n1", xlog[k + 3 + BIAS], k);
        end
        chk("l1_out_we", n_we, 2);
        chk("l1_out_addr0", olog[0], 0);
        chk("l1_out_addr1", olog[1], 1);
        chk("l1_latency", done_cyc - t_start, BIAS ? 30 : 28);

        // zero inputs: straight to FIN
        clear_log();
        start_layer(0, 5);
        wait_done(20);
        chk("z_latency", done_cyc - t_start, 2);
        chk("z_mem_rd", n_rd, 0);
        chk("z_mac_ce", n_ce, 0);
        chk("z_out_we", n_we, 0);

        // start re-pulsed while busy
        clear_log();
        start_layer(1, 2);
        repeat (3) step();
        chk("rp_busy", int'(busy), 1);
        start = 1'b1;
        num_in = 8'd5;
        num_out = 8'd4;
        step();
        start = 1'b0;
        wait_done(200);
        chk("rp_out_we", n_we, 2);
        chk("rp_mem_rd", n_rd, BIAS ? 4 : 2);
        chk("rp_latency", done_cyc - t_start, BIAS ? 26 : 24);

        // reset during WAIT of neuron 1
        clear_log();
        start_layer(3, 2);
        for (int n = 0; n < 200 && !(n_we == 1 && act_start); n++) step();
        chk("mr_reached_act1", int'(act_start), 1);
        step();
        chk("mr_busy_pre", int'(busy), 1);
        reset = 1'b0;
        step();
        chk_idle_outputs("midrst");
        reset = 1'b1;
        start = 1'b1;
        num_in = 8'd1;
        num_out = 8'd1;
        step();
        start = 1'b0;
        chk("rel_start_ignored", int'(busy), 0);
        step();
        chk("rel_still_idle", int'(busy), 0);
        clear_log();
        start_layer(1, 1);
        wait_done(100);
        chk("fr_out_we", n_we, 1);
        chk("fr_out_addr", olog[0], 0);
        chk("fr_mac_ce", n_ce, 1 + BIAS);
        chk("fr_latency", done_cyc - t_start, BIAS ? 14 : 13);

        // act_done stuck high
        clear_log();
        act_mode = 1'b1;
        start_layer(2, 3);
        wait_done(200);
        act_mode = 1'b0;
        chk("ah_out_we", n_we, 3);
        for (int k = 0; k < 3; k++) chk("ah_out_addr", olog[k], k);
        chk("ah_latency", done_cyc - t_start, BIAS ? 32 : 29);
        step();

        // bias row term
        clear_log();
        start_layer(2, 2);
        wait_done(200);
        chk("b_mac_ce", n_ce, BIAS ? 6 : 4);
        chk("b_bias_cnt", n_bias, BIAS ? 2 : 0);
        if (BIAS != 0) begin
            chk("b_bias_w0", bias_w[0], 2);
            chk("b_bias_w1", bias_w[1], 5);
        end
        for (int k = 0; k < (BIAS ? 6 : 4); k++) chk("b_w_addr", wlog[k], k);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
